// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// spi_flash_responder
// Device side of the SPI flash link driven by SPILoader. Decodes READ (0x03),
// JEDEC ID (0x9F) and read status (0x05) and serves image bytes from a
// byte-wide memory over MISO (SPI mode 0, MSB first). All SPI pins are
// oversampled on MCLK through 2-flop synchronizers.
// Optional feature: define SPI_RESPONDER_FASTREAD_EN to decode FAST READ
// (0x0B) with 8 dummy clocks; without it 0x0B is an unknown command.
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS = 22,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic                 MCLK,
    input  logic                 nRESET,
    input  logic                 nCS,
    input  logic                 CLK,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic                 MISO_OE,
    output logic [ADDR_BITS-1:0] ROMADDR,
    output logic                 ROMRD,
    input  logic [7:0]           ROMDATA
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR,
`ifdef SPI_RESPONDER_FASTREAD_EN
        ST_DUMMY,
`endif
        ST_DATA, ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        SRC_MEM, SRC_JEDEC, SRC_STATUS
    } src_t;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t      state, state_next;
    src_t        src;
    logic [1:0]  ncs_sync, clk_sync, mosi_sync;
    logic        ncs_d, clk_d;
    logic        ncs_hi, ncs_fall, clk_rise, clk_fall, mosi_bit;
    logic [4:0]  bit_cnt;
    logic [22:0] shift_in;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_word;
    logic [7:0]  shift_out, prefetch, cur_byte;
    logic        load_next;
    logic [1:0]  byte_idx, idx_next;
    logic        rd_pend, rd_first;
    logic        miso_q;
`ifdef SPI_RESPONDER_FASTREAD_EN
    logic        fast;
`endif

    function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            default: return JEDEC_ID[7:0];
        endcase
    endfunction

    // Input synchronizers plus one edge-detect stage.
    // The nCS chain resets to "selected" so a chip select held low across
    // reset release is not mistaken for a fresh falling edge.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            ncs_sync  <= '0;
            clk_sync  <= '0;
            mosi_sync <= '0;
            ncs_d     <= 1'b0;
            clk_d     <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[0], nCS};
            clk_sync  <= {clk_sync[0], CLK};
            mosi_sync <= {mosi_sync[0], MOSI};
            ncs_d     <= ncs_sync[1];
            clk_d     <= clk_sync[1];
        end
    end

    assign ncs_hi    = ncs_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign ncs_fall  = ncs_d & ~ncs_sync[1];
    assign clk_rise  = clk_sync[1] & ~clk_d;
    assign clk_fall  = ~clk_sync[1] & clk_d;
    assign cmd_byte  = {shift_in[6:0], mosi_bit};
    assign addr_word = {shift_in, mosi_bit};
    assign cur_byte  = load_next ? prefetch : shift_out;
    assign idx_next  = (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;

    // State register.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state logic; a deselected chip returns to IDLE from any state.
    always_comb begin
        state_next = state;
        if (state != ST_IDLE && ncs_hi) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ncs_fall) state_next = ST_CMD;
                ST_CMD: begin
                    if (clk_rise && bit_cnt == 5'd7) begin
                        case (cmd_byte)
                            8'h03:        state_next = ST_ADDR;
`ifdef SPI_RESPONDER_FASTREAD_EN
                            8'h0B:        state_next = ST_ADDR;
`endif
                            8'h9F, 8'h05: state_next = ST_DATA;
                            default:      state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (clk_rise && bit_cnt == 5'd23) begin
`ifdef SPI_RESPONDER_FASTREAD_EN
                        state_next = fast ? ST_DUMMY : ST_DATA;
`else
                        state_next = ST_DATA;
`endif
                    end
                end
`ifdef SPI_RESPONDER_FASTREAD_EN
                ST_DUMMY: if (clk_rise && bit_cnt == 5'd7) state_next = ST_DATA;
`endif
                default: state_next = state;
            endcase
        end
    end

    // Pad outputs: MISO is only driven while serving data.
    always_comb begin
        MISO_OE = (state == ST_DATA);
        MISO    = MISO_OE & miso_q;
    end

    // Datapath: bit counting, command/address shifting, memory fetch and
    // serialization. Memory data is taken two MCLK after ROMRD is raised so a
    // registered-output memory works; the SPI phase limits leave slack.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            src       <= SRC_MEM;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            prefetch  <= '0;
            load_next <= 1'b0;
            byte_idx  <= '0;
            ROMADDR   <= '0;
            ROMRD     <= 1'b0;
            rd_pend   <= 1'b0;
            rd_first  <= 1'b0;
            miso_q    <= 1'b0;
`ifdef SPI_RESPONDER_FASTREAD_EN
            fast      <= 1'b0;
`endif
        end else begin
            ROMRD   <= 1'b0;
            rd_pend <= ROMRD;
            if (rd_pend && state != ST_IDLE && state_next != ST_IDLE) begin
                if (rd_first) shift_out <= ROMDATA;
                else          prefetch  <= ROMDATA;
            end

            if (state_next == ST_IDLE) begin
                bit_cnt   <= '0;
                shift_in  <= '0;
                load_next <= 1'b0;
                miso_q    <= 1'b0;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (clk_rise) begin
                            shift_in <= {shift_in[21:0], mosi_bit};
                            if (bit_cnt == 5'd7) begin
                                bit_cnt  <= '0;
                                byte_idx <= '0;
                                case (cmd_byte)
                                    8'h9F: begin
                                        src       <= SRC_JEDEC;
                                        shift_out <= JEDEC_ID[23:16];
                                    end
                                    8'h05: begin
                                        src       <= SRC_STATUS;
                                        shift_out <= '0;
                                    end
                                    default: src <= SRC_MEM;
                                endcase
`ifdef SPI_RESPONDER_FASTREAD_EN
                                fast <= (cmd_byte == 8'h0B);
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (clk_rise) begin
                            shift_in <= {shift_in[21:0], mosi_bit};
                            if (bit_cnt == 5'd23) begin
                                bit_cnt  <= '0;
                                ROMADDR  <= ADDR_BITS'(addr_word);
                                ROMRD    <= 1'b1;
                                rd_first <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
`ifdef SPI_RESPONDER_FASTREAD_EN
                    ST_DUMMY: begin
                        if (clk_rise) begin
                            if (bit_cnt == 5'd7) bit_cnt <= '0;
                            else                 bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
`endif
                    ST_DATA: begin
                        if (clk_fall) begin
                            miso_q    <= cur_byte[7];
                            shift_out <= {cur_byte[6:0], 1'b0};
                            load_next <= 1'b0;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                load_next <= 1'b1;
                                case (src)
                                    SRC_MEM: begin
                                        ROMADDR  <= ROMADDR + ADDR_ONE;
                                        ROMRD    <= 1'b1;
                                        rd_first <= 1'b0;
                                    end
                                    SRC_JEDEC: begin
                                        prefetch <= jedec_byte(idx_next);
                                        byte_idx <= idx_next;
                                    end
                                    default: prefetch <= '0;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
